cache_mem_bridge: RTL
=====================

Name: cache_mem_bridge

Overview:
- Sits directly downstream of the set-associative cache controller and upstream of the DDR request/response FIFO.
- Converts whole-line cache miss traffic into sequenced memory transactions. Traffic types: line fill, line write-back, and the combined dirty-victim write-back followed by fill.
- Provides a single-outstanding valid/ready request channel towards the cache, a response pulse with the fill data, and a read-response timeout.

Parameters:
- LINE_SIZE, 128, cache line width in bits (one memory beat)
- ADDR_LEN, 27, byte address width
- OFFSET_LEN, 4, line offset bits; forced to zero on every memory address
- TIMEOUT, 1024, max cycles waiting for a read response (≥2)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- creq_valid  in  1  cache request valid
- creq_ready  out  1  bridge accepts request (IDLE only)
- creq_op  in  2  00 fill, 01 write-back, 10 write-back+fill, 11 reserved
- creq_addr  in  ADDR_LEN  fill address (ops 00/10)
- creq_wb_addr  in  ADDR_LEN  victim address (ops 01/10)
- creq_wdata  in  LINE_SIZE  victim line data
- cresp_valid  out  1  one-cycle completion pulse
- cresp_rdata  out  LINE_SIZE  fill data; valid with cresp_valid for ops 00/10
- cresp_err  out  1  with cresp_valid: request timed out or was reserved op
- mreq_en  out  1  memory request valid
- mreq_rdy  in  1  memory accepts request
- mreq_cmd  out  1  1 write, 0 read
- mreq_addr  out  ADDR_LEN  line-aligned address
- mreq_data  out  LINE_SIZE  write data (0 on reads)
- mrsp_en  in  1  read response valid
- mrsp_data  in  LINE_SIZE  read response data
- mrsp_rdy  out  1  bridge accepts response (RD_WAIT only)

Behaviour:
- Reset (rstn=0 at clk edge), any state:
  - State goes to IDLE.
  - All outputs are 0 except creq_ready. mreq_en, cresp_valid, cresp_err, mrsp_rdy = 0; mreq_addr/mreq_data/cresp_rdata = 0.
  - creq_ready = 1 from the first cycle after reset release.
  - The timeout counter is cleared.
  - An in-flight transaction is abandoned with no response.
- Capture:
  - Happens on creq_valid & creq_ready.
  - op, both addresses and wdata are registered.
  - Addresses are stored with bits [OFFSET_LEN-1:0] zeroed.
  - creq_ready drops the next cycle and stays low until the state returns to IDLE.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, RESP.
- IDLE on capture:
  - op 01/10 → WR_REQ.
  - op 00 → RD_REQ.
  - op 11 → RESP with err = 1.
- WR_REQ:
  - mreq_en = 1, cmd = 1, addr = wb_addr, data = wdata, all held stable until mreq_rdy.
  - On mreq_en & mreq_rdy: op 01 → RESP; op 10 → RD_REQ.
  - Writes get no memory response.
- RD_REQ:
  - mreq_en = 1, cmd = 0, addr = fill addr, data = 0, held until mreq_rdy.
  - On accept → RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - mrsp_rdy = 1.
  - On mrsp_en: capture mrsp_data into cresp_rdata → RESP, err = 0.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without mrsp_en → RESP, err = 1, rdata = 0.
  - If mrsp_en arrives on the terminal count cycle, data wins (err = 0).
- RESP:
  - cresp_valid = 1 for exactly one cycle; cresp_err is valid with it; cresp_rdata is held until the next capture.
  - Next state IDLE.
  - For op 01, cresp_rdata = 0.
- mreq_en deasserts the cycle after acceptance. Registered outputs give no combinational path from mreq_rdy to mreq_en.
- mrsp_en outside RD_WAIT is ignored and dropped (mrsp_rdy = 0).
- creq_valid is ignored while creq_ready = 0; no queueing.
- Latency, mreq_rdy tied high:
  - Op 01: capture at edge N, mreq_en in N+1, cresp_valid in N+2.
  - Op 00: capture N, mreq_en N+1, RD_WAIT from N+2. mrsp_en at cycle M ≥ N+2 gives cresp_valid at M+1.
  - Op 10: as op 00, shifted by one extra cycle.
- Timeout counter width: $clog2(TIMEOUT). It does not wrap; it is only active in RD_WAIT.

Test Plan:
- Fill: op 00, addr 0x0001234 (low nibble nonzero), mreq_rdy = 1, mrsp_en 3 cycles after accept with data 0xDEADBEEF_…_0001 → mreq_addr 0x0001230, cmd 0, cresp_valid single pulse with that data, err 0.
- Write-back under backpressure: op 01, wb_addr 0x0ABCDE0, wdata pattern A5…, mreq_rdy low 5 cycles → mreq_en/addr/data stable for 6 cycles; cresp_valid 1 cycle after accept, rdata 0; no read issued.
- Write-back+fill: op 10 → write to wb_addr 0x0000100 accepted, then read to addr 0x0000200. Order must be write-then-read; response carries the read data.
- Timeout: TIMEOUT = 16, op 00, no mrsp_en → cresp_valid with err 1 exactly 16 cycles after read accept, rdata 0. A later mrsp_en is ignored and the next request succeeds normally.
- Stray/simultaneous: mrsp_en pulsed in IDLE → no cresp_valid. creq_valid held during busy → only one capture. mrsp_en on the terminal timeout cycle → err 0, data returned.
- Reset mid-operation: rstn low in RD_WAIT → next cycle all outputs 0, creq_ready 1 after release, no cresp_valid; a subsequent op 01 completes with standard latency.

Source files
------------

// File: rtl/cache_mem_bridge.sv
// Bridge between the cache controller miss path and the DDR request/response FIFO.
// Sequences line fills, write-backs and dirty-victim write-back-then-fill with a read timeout.
module cache_mem_bridge #(
  parameter int LINE_SIZE  = 128,
  parameter int ADDR_LEN   = 27,
  parameter int OFFSET_LEN = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 creq_valid,
  output logic                 creq_ready,
  input  logic [1:0]           creq_op,
  input  logic [ADDR_LEN-1:0]  creq_addr,
  input  logic [ADDR_LEN-1:0]  creq_wb_addr,
  input  logic [LINE_SIZE-1:0] creq_wdata,
  output logic                 cresp_valid,
  output logic [LINE_SIZE-1:0] cresp_rdata,
  output logic                 cresp_err,
  output logic                 mreq_en,
  input  logic                 mreq_rdy,
  output logic                 mreq_cmd,
  output logic [ADDR_LEN-1:0]  mreq_addr,
  output logic [LINE_SIZE-1:0] mreq_data,
  input  logic                 mrsp_en,
  input  logic [LINE_SIZE-1:0] mrsp_data,
  output logic                 mrsp_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_LEN-1:0] LINE_MASK = ~ADDR_LEN'((1 << OFFSET_LEN) - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b01;
  localparam logic [1:0] OP_WBF  = 2'b10;

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mreq_cmd_q, mreq_cmd_d;
  logic [ADDR_LEN-1:0]  mreq_addr_q, mreq_addr_d;
  logic [LINE_SIZE-1:0] mreq_data_q, mreq_data_d;
  logic [LINE_SIZE-1:0] cresp_rdata_q, cresp_rdata_d;
  logic                 cresp_err_q, cresp_err_d;

  // Handshake strobes decode straight from the state flop: no path from mreq_rdy to mreq_en.
  assign creq_ready  = (state_q == S_IDLE);
  assign mreq_en     = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign mrsp_rdy    = (state_q == S_RD_WAIT);
  assign cresp_valid = (state_q == S_RESP);
  assign mreq_cmd    = mreq_cmd_q;
  assign mreq_addr   = mreq_addr_q;
  assign mreq_data   = mreq_data_q;
  assign cresp_rdata = cresp_rdata_q;
  assign cresp_err   = cresp_err_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    mreq_cmd_d    = mreq_cmd_q;
    mreq_addr_d   = mreq_addr_q;
    mreq_data_d   = mreq_data_q;
    cresp_rdata_d = cresp_rdata_q;
    cresp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (creq_valid) begin
          op_d          = creq_op;
          addr_d        = creq_addr & LINE_MASK;
          cresp_rdata_d = '0;
          // The first memory beat is loaded straight from the request inputs.
          case (creq_op)
            OP_WB, OP_WBF: begin
              state_d     = S_WR_REQ;
              mreq_cmd_d  = 1'b1;
              mreq_addr_d = creq_wb_addr & LINE_MASK;
              mreq_data_d = creq_wdata;
            end
            OP_FILL: begin
              state_d     = S_RD_REQ;
              mreq_cmd_d  = 1'b0;
              mreq_addr_d = creq_addr & LINE_MASK;
              mreq_data_d = '0;
            end
            default: begin
              state_d     = S_RESP;
              cresp_err_d = 1'b1;
            end
          endcase
        end
      end

      S_WR_REQ: begin
        if (mreq_rdy) begin
          mreq_cmd_d  = 1'b0;
          mreq_data_d = '0;
          if (op_q == OP_WBF) begin
            state_d     = S_RD_REQ;
            mreq_addr_d = addr_q;
          end else begin
            state_d     = S_RESP;
            mreq_addr_d = '0;
          end
        end
      end

      S_RD_REQ: begin
        if (mreq_rdy) begin
          state_d     = S_RD_WAIT;
          cnt_d       = '0;
          mreq_cmd_d  = 1'b0;
          mreq_addr_d = '0;
          mreq_data_d = '0;
        end
      end

      S_RD_WAIT: begin
        // Data arriving on the terminal count cycle still wins over the timeout.
        if (mrsp_en) begin
          state_d       = S_RESP;
          cresp_rdata_d = mrsp_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          cresp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      mreq_cmd_q    <= 1'b0;
      mreq_addr_q   <= '0;
      mreq_data_q   <= '0;
      cresp_rdata_q <= '0;
      cresp_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      mreq_cmd_q    <= mreq_cmd_d;
      mreq_addr_q   <= mreq_addr_d;
      mreq_data_q   <= mreq_data_d;
      cresp_rdata_q <= cresp_rdata_d;
      cresp_err_q   <= cresp_err_d;
    end
  end

endmodule
